// File: rtl/alu_wb_stage.sv
// Writeback stage behind the 4-bit ALU: a 2-entry result FIFO drives the register-file
// write port, updates Z/N/C on retirement and answers pending-destination hazard queries.
module alu_wb_stage #(
  parameter int WIDTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic [AW-1:0]    in_dest,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic             rf_ack,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  input  logic [AW-1:0]    query_addr,
  output logic             query_hit,
  output logic [CNT_W-1:0] wb_count
);

  logic [AW-1:0]    dest_r  [0:1];
  logic [WIDTH-1:0] res_r   [0:1];
  logic             carry_r [0:1];
  logic             rd_ptr_r;
  logic             wr_ptr_r;
  logic [1:0]       count_r;

  logic             push_s;
  logic             pop_s;
  logic             rd_next_s;
  logic [1:0]       count_next_s;
  logic [AW-1:0]    head_dest_s;
  logic [WIDTH-1:0] head_res_s;
  logic             hit_s;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  assign in_ready = (count_r != 2'd2);
  assign push_s   = in_valid & in_ready;
  assign pop_s    = rf_we & rf_ack;

  // Next occupancy and the head entry the write port will present after this edge
  always_comb begin
    count_next_s = count_r;
    rd_next_s    = rd_ptr_r ^ pop_s;
    head_dest_s  = {AW{1'b0}};
    head_res_s   = {WIDTH{1'b0}};
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
    // An incoming result becomes the head when it lands in the slot the read pointer moves to
    if (count_next_s == 2'd0) begin
      head_dest_s = {AW{1'b0}};
      head_res_s  = {WIDTH{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_dest_s = in_dest;
      head_res_s  = in_result;
    end else begin
      head_dest_s = dest_r[rd_next_s];
      head_res_s  = res_r[rd_next_s];
    end
  end

  // Hazard lookup over the occupied FIFO slots; the head stays pending until it pops
  always_comb begin
    hit_s = 1'b0;
    if (count_r != 2'd0) begin
      hit_s = (dest_r[rd_ptr_r] == query_addr);
    end else begin
      hit_s = 1'b0;
    end
    if (count_r == 2'd2) begin
      hit_s = hit_s | (dest_r[~rd_ptr_r] == query_addr);
    end else begin
      hit_s = hit_s;
    end
  end

  assign query_hit = hit_s;

  // FIFO storage, pointers, registered write port, status flags and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        dest_r[i]  <= {AW{1'b0}};
        res_r[i]   <= {WIDTH{1'b0}};
        carry_r[i] <= 1'b0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      rf_we    <= 1'b0;
      rf_waddr <= {AW{1'b0}};
      rf_wdata <= {WIDTH{1'b0}};
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      wb_count <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        dest_r[wr_ptr_r]  <= in_dest;
        res_r[wr_ptr_r]   <= in_result;
        carry_r[wr_ptr_r] <= in_carry;
      end
      wr_ptr_r <= wr_ptr_r ^ push_s;
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      rf_we    <= (count_next_s != 2'd0);
      rf_waddr <= head_dest_s;
      rf_wdata <= head_res_s;
      if (pop_s) begin
        flag_z   <= is_zero(res_r[rd_ptr_r]);
        flag_n   <= res_r[rd_ptr_r][WIDTH-1];
        flag_c   <= carry_r[rd_ptr_r];
        wb_count <= wb_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
